ram2_arbiter: RTL
=================

Name: ram2_arbiter

Overview:
- Shares the single RAM2 controller port between three requesters: boot init copier (INIT), data memory stage (MEM) and instruction fetch (IF).
- Applies fixed priority INIT > MEM > IF, with an IF starvation guard and a timeout watchdog on the downstream handshake.
- Sits between the IF/MEM stages and the RAM2 controller.
- Exports a 16-bit status word so the LED/VGA debug mux can show the arbiter's state.

Parameters:
STARVE_LIMIT, 4, consecutive MEM grants while if_req is waiting before IF is forced to win (INIT still overrides)
TIMEOUT, 255, maximum BUSY cycles waiting for ram_work_done before the access is aborted

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
init_req  in  1  INIT write request; held until init_done
init_addr  in  16  INIT word address
init_data  in  16  INIT write data
init_done  out  1  one-cycle completion pulse for INIT
mem_req  in  1  MEM request; held until mem_done
mem_wr  in  1  MEM direction: 1 = write, 0 = read
mem_addr  in  16  MEM address
mem_wdata  in  16  MEM write data
mem_done  out  1  one-cycle completion pulse for MEM
mem_rdata  out  16  MEM read result; valid while mem_done is high and held afterwards
if_req  in  1  IF read request; held until if_done
if_addr  in  16  IF address (PC)
if_done  out  1  one-cycle completion pulse for IF
if_rdata  out  16  fetched instruction; valid while if_done is high and held afterwards
ram_need_to_work  out  1  downstream request, held high until ram_work_done
ram_wr  out  1  downstream direction
ram_addr  out  16  downstream address
ram_wdata  out  16  downstream write data
ram_work_done  in  1  downstream completion (level or pulse)
ram_work_res  in  16  downstream read data, valid while ram_work_done is high
hold  out  1  pipeline stall request
err  out  1  sticky timeout flag
status  out  16  debug word: {state[1:0], owner[1:0], err, starve_cnt[2:0], grant_cnt[7:0]}

Behaviour:
- Reset (synchronous, active-high): state = IDLE, owner = 0, and all outputs, counters and err = 0.
- A reset mid-access abandons the access: no done pulse is issued and ram_need_to_work drops at the next edge.
- Owner encoding: 0 = none, 1 = INIT, 2 = MEM, 3 = IF.
- State machine:
  - IDLE: if any req is high, select the winner; latch owner, addr, wdata and wr (INIT forces wr = 1, IF forces wr = 0); go to BUSY. Otherwise stay in IDLE.
  - BUSY: ram_need_to_work = 1 and the downstream buses drive the latched values.
    - On ram_work_done = 1: capture ram_work_res into the owner's rdata register and go to RELEASE.
    - On timeout counter == TIMEOUT: set err, load rdata = 16'hFFFF, go to RELEASE.
  - RELEASE: ram_need_to_work = 0; the owner's done is high for exactly this cycle; grant_cnt increments (wraps at 8 bits); next state is IDLE.
- Winner selection:
  - init_req wins if high.
  - Otherwise IF wins if if_req is high and starve_cnt == STARVE_LIMIT.
  - Otherwise MEM wins if mem_req is high.
  - Otherwise IF wins if if_req is high.
- starve_cnt:
  - Increments, saturating at STARVE_LIMIT, on each MEM grant made while if_req is high.
  - Clears on an IF grant or whenever if_req is low in IDLE.
- Latency:
  - Request seen in IDLE at cycle N: ram_need_to_work is high from N+1.
  - ram_work_done sampled at cycle M: done pulse at M+1; the next grant decision is at M+2.
  - Minimum access occupies 3 cycles.
- Requester rule: req must be low by the IDLE cycle after done if no further access is wanted. A req still high there is a new request.
- A ram_work_done arriving in IDLE or RELEASE is ignored.
- The timeout counter clears on entry to BUSY.
- Simultaneous ram_work_done and timeout in the same cycle: the done wins; err is not set.
- hold is combinational: hold = (mem_req & ~mem_done) | (if_req & ~if_done) | init_req.
- Address and data are registered at grant; requester changes during BUSY are ignored.

Test Plan:
- Single IF read: if_addr = 16'h0010, downstream done 2 cycles after need_to_work rises with res = 16'h6801 -> if_done pulses once at M+1, if_rdata = 16'h6801, grant_cnt = 1.
- MEM and IF requesting in the same IDLE cycle: mem_wr = 1, mem_addr = 16'hBF00, mem_wdata = 16'h00AA -> MEM granted first, ram_wr = 1, ram_addr = 16'hBF00; IF is granted right after mem_done.
- MEM held continuously with IF waiting, STARVE_LIMIT = 4 -> grant order is MEM ×4, then IF, then MEM; starve_cnt shows 4 and then 0 in status.
- INIT asserted while MEM is mid-access -> MEM completes undisturbed, then INIT is granted ahead of pending MEM/IF; init_done pulses; ram_wr = 1 with init_data passed through.
- Downstream never responds, TIMEOUT = 255 -> ram_need_to_work drops after 255 BUSY cycles; mem_done pulses with mem_rdata = 16'hFFFF; err = 1 and stays set until rst.
- rst asserted during BUSY -> next cycle state = IDLE, ram_need_to_work = 0, no done pulse, err = 0, status = 16'h0000.

Source files
------------

// File: rtl/ram2_arbiter.sv
// Arbitrates the single RAM2 controller port between INIT, MEM and IF requesters.
// Fixed priority INIT > MEM > IF, with an IF starvation guard and a downstream watchdog.
module ram2_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        init_req,
    input  logic [15:0] init_addr,
    input  logic [15:0] init_data,
    output logic        init_done,
    input  logic        mem_req,
    input  logic        mem_wr,
    input  logic [15:0] mem_addr,
    input  logic [15:0] mem_wdata,
    output logic        mem_done,
    output logic [15:0] mem_rdata,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic        if_done,
    output logic [15:0] if_rdata,
    output logic        ram_need_to_work,
    output logic        ram_wr,
    output logic [15:0] ram_addr,
    output logic [15:0] ram_wdata,
    input  logic        ram_work_done,
    input  logic [15:0] ram_work_res,
    output logic        hold,
    output logic        err,
    output logic [15:0] status
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_BUSY    = 2'd1;
    localparam logic [1:0] S_RELEASE = 2'd2;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_INIT = 2'd1;
    localparam logic [1:0] OWN_MEM  = 2'd2;
    localparam logic [1:0] OWN_IF   = 2'd3;

    localparam int             TW         = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    // Counter holds completed BUSY cycles, so this value marks the last permitted one.
    localparam logic [TW-1:0]  TMO_LAST   = TW'(TIMEOUT - 1);
    localparam logic [2:0]     STARVE_MAX = 3'(STARVE_LIMIT);

    logic [1:0]    r_state;
    logic [1:0]    r_owner;
    logic          r_wr;
    logic [15:0]   r_addr;
    logic [15:0]   r_wdata;
    logic [15:0]   r_mem_rdata;
    logic [15:0]   r_if_rdata;
    logic [TW-1:0] r_tmo;
    logic [2:0]    r_starve_cnt;
    logic [7:0]    r_grant_cnt;
    logic          r_err;

    logic [1:0]    w_winner;
    logic          w_sel_wr;
    logic [15:0]   w_sel_addr;
    logic [15:0]   w_sel_wdata;
    logic          w_release;
    logic          w_tmo_hit;
    logic [15:0]   w_result;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_winner = OWN_NONE;
        if (init_req)
            w_winner = OWN_INIT;
        else if (if_req && r_starve_cnt == STARVE_MAX)
            w_winner = OWN_IF;
        else if (mem_req)
            w_winner = OWN_MEM;
        else if (if_req)
            w_winner = OWN_IF;
    end

    always_comb begin
        w_sel_wr    = 1'b0;
        w_sel_addr  = 16'h0000;
        w_sel_wdata = 16'h0000;
        case (w_winner)
            OWN_INIT: begin
                w_sel_wr    = 1'b1;
                w_sel_addr  = init_addr;
                w_sel_wdata = init_data;
            end
            OWN_MEM: begin
                w_sel_wr    = mem_wr;
                w_sel_addr  = mem_addr;
                w_sel_wdata = mem_wdata;
            end
            OWN_IF: begin
                w_sel_addr  = if_addr;
            end
            default: ;
        endcase
    end

    assign w_tmo_hit = (r_tmo == TMO_LAST);
    assign w_result  = ram_work_done ? ram_work_res : 16'hFFFF;

    // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_owner      <= OWN_NONE;
            r_wr         <= 1'b0;
            r_addr       <= 16'h0000;
            r_wdata      <= 16'h0000;
            r_mem_rdata  <= 16'h0000;
            r_if_rdata   <= 16'h0000;
            r_tmo        <= '0;
            r_starve_cnt <= 3'd0;
            r_grant_cnt  <= 8'd0;
            r_err        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!if_req)
                        r_starve_cnt <= 3'd0;
                    if (w_winner != OWN_NONE) begin
                        r_owner <= w_winner;
                        r_wr    <= w_sel_wr;
                        r_addr  <= w_sel_addr;
                        r_wdata <= w_sel_wdata;
                        r_tmo   <= '0;
                        r_state <= S_BUSY;
                        if (w_winner == OWN_IF)
                            r_starve_cnt <= 3'd0;
                        else if (w_winner == OWN_MEM && if_req && r_starve_cnt < STARVE_MAX)
                            r_starve_cnt <= r_starve_cnt + 3'd1;
                    end
                end
                S_BUSY: begin
                    // A completion in the same cycle as the timeout takes precedence.
                    if (ram_work_done || w_tmo_hit) begin
                        r_state <= S_RELEASE;
                        if (!ram_work_done)
                            r_err <= 1'b1;
                        if (r_owner == OWN_MEM)
                            r_mem_rdata <= w_result;
                        else if (r_owner == OWN_IF)
                            r_if_rdata <= w_result;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                S_RELEASE: begin
                    r_grant_cnt <= r_grant_cnt + 8'd1;
                    r_owner     <= OWN_NONE;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_release        = (r_state == S_RELEASE);
    assign init_done        = w_release && (r_owner == OWN_INIT);
    assign mem_done         = w_release && (r_owner == OWN_MEM);
    assign if_done          = w_release && (r_owner == OWN_IF);
    assign mem_rdata        = r_mem_rdata;
    assign if_rdata         = r_if_rdata;

    assign ram_need_to_work = (r_state == S_BUSY);
    assign ram_wr           = r_wr;
    assign ram_addr         = r_addr;
    assign ram_wdata        = r_wdata;

    assign hold   = (mem_req & ~mem_done) | (if_req & ~if_done) | init_req;
    assign err    = r_err;
    assign status = {r_state, r_owner, r_err, r_starve_cnt, r_grant_cnt};

endmodule
